fp_int_acc: RTL and testbench
=============================

FP_INT_ACC -- requirements
Module: fp_int_acc

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 56, meaning the width of the signed fixed-point accumulator, LSB weight 2^-25.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port sign_in, input, 1 bit: product sign from the upstream fp-int multiplier.
REQ-005 SHALL have port exp_in, input, 5 bits: biased fp16 exponent of the product.
REQ-006 SHALL have port mantissa_in, input, 14 bits: unsigned 4.10 fixed-point product magnitude.
REQ-007 SHALL have port start_acc, input, 1 bit: one-cycle strobe; product inputs are valid in this cycle.
REQ-008 SHALL have port acc_len, input, 8 bits: number of products per result; 0 is treated as 1.
REQ-009 SHALL have port clear, input, 1 bit: synchronous abort and flush.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port result, output, 32 bits: IEEE fp32 sum of the accumulated products.
REQ-012 SHALL have port result_valid, output, 1 bit: result is held stable while this is high.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port err_overrun, output, 1 bit: sticky flag for a dropped product.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, NORM and OUT.
REQ-016 SHALL sample sign_in, exp_in and mantissa_in only in cycles where start_acc=1.
REQ-017 SHALL form each product term as mantissa_in << exp_in, sign-extended and negated (two's complement) when sign_in=1; represented value = mantissa_in * 2^(exp_in-25).
REQ-018 SHALL treat exp_in=0 as a zero term.
REQ-019 SHALL treat exp_in=31 as a special: the term adds zero and a special flag is set for the current result.
REQ-020 SHALL, in IDLE on start_acc, load acc with the term and count with 1, latch acc_len, then go to NORM if the latched length is at most 1, else to ACCUM.
REQ-021 SHALL, in ACCUM on start_acc, set acc <= acc + term and count++, and go to NORM when count reaches the latched length.
REQ-022 SHALL spend exactly one cycle in NORM: take the magnitude of acc, find the leading-one position p (0..ACC_WIDTH-2) and register the fp32 result.
REQ-023 SHALL compute the fp32 fields as: sign = acc MSB; exponent = p + 102; fraction = the 23 bits below p, left-aligned and zero-filled when p < 23, truncated toward zero.
REQ-024 SHALL output result 0x00000000 when acc is zero.
REQ-025 SHALL output result 0x7FC00000 when the special flag is set.
REQ-026 SHALL assert result_valid in OUT and return to IDLE in the cycle where out_ready=1.
REQ-027 SHALL give latency from the last start_acc edge to result_valid high of 2 cycles.
REQ-028 SHALL drop a start_acc arriving in NORM or OUT, with acc, count and result unchanged, and set err_overrun.
REQ-029 SHALL NOT wrap the accumulator for 255 max-magnitude terms, since ACC_WIDTH=56 covers 44 + 8 bits plus sign.
REQ-030 SHALL give clear priority over start_acc and out_ready: go to IDLE, zero acc/count/special, drop result_valid, reset err_overrun.
REQ-031 SHALL sample acc_len changes only at the IDLE->busy transition.

Reset
REQ-032 SHALL, on rst low and asynchronously, set state IDLE, acc=0, count=0, result=0, result_valid=0, busy=0, err_overrun=0 and special=0.
REQ-033 SHALL, on reset mid-ACCUM, discard partial sums with no result emitted; the first start_acc after release starts a new result.

Structure
REQ-034 SHALL place FP16_EXP_W=5, PROD_MANT_W=14, FP32_BIAS=127, ACC_LSB_EXP=-25, the NaN constant 0x7FC00000 and the state enum in shared package fp_int_pkg.
REQ-035 SHALL instantiate one sub-module, lead_one_det, as a combinational priority encoder over ACC_WIDTH-1 bits returning p and a zero flag.
REQ-036 SHALL register all outputs; there is no combinational path from inputs to outputs.

Verification
REQ-037 SHALL cover: acc_len=1, start_acc with sign=0, exp=15, mant=0x400 -> result 0x3F800000, result_valid 2 cycles later.
REQ-038 SHALL cover: acc_len=3, three terms of +2.0 (exp=16, mant=0x400) -> 0x40C00000; then acc_len=2, +1.0 and -1.0 -> 0x00000000.
REQ-039 SHALL cover: acc_len=2, terms (exp=31) and +1.0 -> 0x7FC00000.
REQ-040 SHALL cover: out_ready low for 5 cycles in OUT plus one start_acc -> result held, err_overrun=1, busy=1; clear -> IDLE, err_overrun=0.
REQ-041 SHALL cover: acc_len=255, all terms exp=30, mant=0x3FFF, sign=0 -> result equals the truncated fp32 of 255*16383*2^5 (positive, no wrap).
REQ-042 SHALL cover: rst low after 2 of 4 terms, then 4 fresh +1.0 terms -> 0x40800000.

Source files
------------

// File: rtl/fp_int_pkg.sv
// Shared constants and FSM encoding for the fp16-exponent / integer-mantissa accumulator.
package fp_int_pkg;
  localparam int FP16_EXP_W  = 5;
  localparam int PROD_MANT_W = 14;
  localparam int FP32_BIAS   = 127;
  localparam int ACC_LSB_EXP = -25;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_OFS = 8'(FP32_BIAS + ACC_LSB_EXP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    NORM  = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/lead_one_det.sv
// Combinational priority encoder: position of the highest set bit and an all-zero flag.
module lead_one_det #(
  parameter int W     = 55,
  parameter int POS_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [POS_W-1:0] pos,
  output logic             zero
);
  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        pos  = POS_W'(i);
        zero = 1'b0;
      end
    end
  end
endmodule

// File: rtl/fp_int_acc.sv
// Accumulates fp16-scaled integer products in fixed point and emits one fp32 sum per acc_len terms.
// Handshake: result_valid rises with a stable result and stays until a cycle with out_ready=1.
module fp_int_acc
  import fp_int_pkg::*;
#(
  parameter int ACC_WIDTH = 56
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sign_in,
  input  logic [FP16_EXP_W-1:0]  exp_in,
  input  logic [PROD_MANT_W-1:0] mantissa_in,
  input  logic                   start_acc,
  input  logic [7:0]             acc_len,
  input  logic                   clear,
  input  logic                   out_ready,
  output logic [31:0]            result,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   err_overrun,
  output state_t                 dbg_state
);
  localparam int POS_W = $clog2(ACC_WIDTH - 1);

  state_t                 state, state_n;
  logic [ACC_WIDTH-1:0]   acc, acc_n;
  logic [7:0]             count, count_n, len_q, len_n;
  logic                   special, special_n, err_n;
  logic [31:0]            result_n;

  logic [ACC_WIDTH-1:0]   term_mag, term;
  logic                   term_special;
  logic [ACC_WIDTH-1:0]   mag;
  logic [POS_W-1:0]       lead_pos;
  logic                   acc_zero;
  logic [22:0]            frac;
  logic [7:0]             exp_f;
  logic [31:0]            norm_result;

  // exp 0 is a zero term; exp 31 is a special that contributes nothing but forces NaN.
  assign term_special = (exp_in == '1);
  assign term_mag     = ACC_WIDTH'(mantissa_in) << exp_in;
  assign term         = (exp_in == '0 || term_special) ? '0 :
                        (sign_in ? -term_mag : term_mag);

  assign mag = acc[ACC_WIDTH-1] ? -acc : acc;

  lead_one_det #(.W(ACC_WIDTH - 1), .POS_W(POS_W)) u_lod (
    .vec  (mag[ACC_WIDTH-2:0]),
    .pos  (lead_pos),
    .zero (acc_zero)
  );

  always_comb begin
    if (lead_pos >= POS_W'(23)) frac = 23'(mag >> (lead_pos - POS_W'(23)));
    else                        frac = 23'(mag << (POS_W'(23) - lead_pos));
    exp_f = 8'(lead_pos) + FP32_EXP_OFS;
    if (special)       norm_result = FP32_QNAN;
    else if (acc_zero) norm_result = '0;
    else               norm_result = {acc[ACC_WIDTH-1], exp_f, frac};
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    count_n   = count;
    len_n     = len_q;
    special_n = special;
    err_n     = err_overrun;
    result_n  = result;
    if (clear) begin
      state_n   = IDLE;
      acc_n     = '0;
      count_n   = '0;
      special_n = 1'b0;
      err_n     = 1'b0;
    end else begin
      case (state)
        IDLE: if (start_acc) begin
          acc_n     = term;
          count_n   = 8'd1;
          len_n     = (acc_len == 8'd0) ? 8'd1 : acc_len;
          special_n = term_special;
          state_n   = (len_n == 8'd1) ? NORM : ACCUM;
        end
        ACCUM: if (start_acc) begin
          acc_n     = acc + term;
          count_n   = count + 8'd1;
          special_n = special | term_special;
          if (count_n == len_q) state_n = NORM;
        end
        NORM: begin
          result_n = norm_result;
          state_n  = OUT;
          if (start_acc) err_n = 1'b1;
        end
        OUT: begin
          if (start_acc) err_n = 1'b1;
          if (out_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      len_q        <= 8'd1;
      special      <= 1'b0;
      err_overrun  <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      acc          <= acc_n;
      count        <= count_n;
      len_q        <= len_n;
      special      <= special_n;
      err_overrun  <= err_n;
      result       <= result_n;
      result_valid <= (state_n == OUT);
      busy         <= (state_n != IDLE);
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_fp_int_acc.sv
// Self-checking bench for fp_int_acc: directed cases plus randomized results against an arithmetic model.
module tb_fp_int_acc;
  import fp_int_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sign_in = 1'b0;
  logic [4:0]  exp_in = '0;
  logic [13:0] mantissa_in = '0;
  logic        start_acc = 1'b0;
  logic [7:0]  acc_len = 8'd1;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        err_overrun;
  state_t      dbg_state;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [31:0] exp_q[$];
  longint      model_sum;
  bit          model_special;

  fp_int_acc #(.ACC_WIDTH(56)) dut (
    .clk          (clk),
    .rst          (rst),
    .sign_in      (sign_in),
    .exp_in       (exp_in),
    .mantissa_in  (mantissa_in),
    .start_acc    (start_acc),
    .acc_len      (acc_len),
    .clear        (clear),
    .out_ready    (out_ready),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err_overrun  (err_overrun),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum in units of 2^-25, converted to fp32 with truncation.
  function automatic logic [31:0] ref_fp32(input longint s, input bit sp);
    longint m;
    int     e;
    longint f;
    bit     neg;
    if (sp) return 32'h7FC0_0000;
    if (s == 0) return 32'h0;
    neg = (s < 0);
    m = neg ? -s : s;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    f = (e >= 23) ? (m >> (e - 23)) : (m << (23 - e));
    return {neg, 8'(e - 25 + 127), 23'(f)};
  endfunction

  function automatic longint term_value(input bit s, input int e, input int m);
    longint v;
    if (e == 0 || e == 31) return 0;
    v = longint'(m) * (longint'(1) << e);
    return s ? -v : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic begin_result();
    model_sum = 0;
    model_special = 1'b0;
  endtask

  task automatic drive_term(input bit s, input int e, input int m);
    @(negedge clk);
    sign_in = s;
    exp_in = 5'(e);
    mantissa_in = 14'(m);
    start_acc = 1'b1;
    model_sum += term_value(s, e, m);
    if (e == 31) model_special = 1'b1;
    @(negedge clk);
    start_acc = 1'b0;
  endtask

  task automatic end_result();
    exp_q.push_back(ref_fp32(model_sum, model_special));
  endtask

  task automatic collect(input string tag, input int hold, input bit has_known, input logic [31:0] known);
    logic [31:0] expv;
    int waited;
    waited = 0;
    while (!result_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, {31'b0, result_valid}, 32'd1);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, result, expv);
    if (has_known) check({tag, "_known"}, result, known);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold"}, result, expv);
      check({tag, "_hold_valid"}, {31'b0, result_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'b0, result_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int len, len_eff;

    repeat (3) @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err_overrun}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // +1.0 alone, checking the two-cycle latency
    acc_len = 8'd1;
    begin_result();
    drive_term(1'b0, 15, 14'h400);
    end_result();
    check("lat_norm_valid", {31'b0, result_valid}, 32'd0);
    check("lat_norm_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("lat_out_valid", {31'b0, result_valid}, 32'd1);
    collect("one", 0, 1'b1, 32'h3F80_0000);

    acc_len = 8'd3;
    begin_result();
    repeat (3) drive_term(1'b0, 16, 14'h400);
    end_result();
    collect("six", 1, 1'b1, 32'h40C0_0000);

    acc_len = 8'd2;
    begin_result();
    drive_term(1'b0, 15, 14'h400);
    drive_term(1'b1, 15, 14'h400);
    end_result();
    collect("cancel", 0, 1'b1, 32'h0);

    acc_len = 8'd2;
    begin_result();
    drive_term(1'b0, 31, 14'h123);
    drive_term(1'b0, 15, 14'h400);
    end_result();
    collect("nan", 0, 1'b1, 32'h7FC0_0000);

    // acc_len 0 behaves as 1
    acc_len = 8'd0;
    begin_result();
    drive_term(1'b1, 16, 14'h600);
    end_result();
    collect("len0", 0, 1'b1, 32'hC040_0000);

    // Stalled output plus a dropped start, then clear
    acc_len = 8'd1;
    begin_result();
    drive_term(1'b0, 16, 14'h400);
    end_result();
    @(negedge clk);
    held = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        sign_in = 1'b1;
        exp_in = 5'd20;
        mantissa_in = 14'h3FFF;
        start_acc = 1'b1;
      end
      @(negedge clk);
      start_acc = 1'b0;
      check("stall_result", result, held);
      check("stall_valid", {31'b0, result_valid}, 32'd1);
      check("stall_busy", {31'b0, busy}, 32'd1);
    end
    check("stall_known", result, 32'h4000_0000);
    check("overrun_set", {31'b0, err_overrun}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_busy", {31'b0, busy}, 32'd0);
    check("clear_valid", {31'b0, result_valid}, 32'd0);
    check("clear_err", {31'b0, err_overrun}, 32'd0);

    // 255 maximum-magnitude terms must not wrap
    acc_len = 8'd255;
    begin_result();
    repeat (255) drive_term(1'b0, 30, 14'h3FFF);
    end_result();
    collect("max255", 0, 1'b1, 32'h4CFE_FC04);

    // Reset after 2 of 4 terms discards the partial sum
    acc_len = 8'd4;
    begin_result();
    drive_term(1'b0, 20, 14'h3AB);
    drive_term(1'b1, 22, 14'h111);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, result_valid}, 32'd0);
    check("midrst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_after_valid", {31'b0, result_valid}, 32'd0);
    acc_len = 8'd4;
    begin_result();
    repeat (4) drive_term(1'b0, 15, 14'h400);
    end_result();
    collect("four", 0, 1'b1, 32'h4080_0000);

    // Randomized results; acc_len changes mid-result must be ignored
    for (int r = 0; r < 30; r++) begin
      len = $urandom_range(0, 6);
      len_eff = (len == 0) ? 1 : len;
      acc_len = 8'(len);
      begin_result();
      for (int t = 0; t < len_eff; t++) begin
        drive_term(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 16383));
        acc_len = 8'($urandom_range(0, 255));
      end
      end_result();
      collect("rand", $urandom_range(0, 3), 1'b0, 32'h0);
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
